// File: rtl/bird_datapath.sv
// -----------------------------------------------------------------------------
// bird_datapath
//
// Per-frame datapath for the bird sprite. Each accepted frame tick runs one
// frame: it erases the sprite at its old position, applies gravity or a flap
// to the vertical velocity and position, and redraws the sprite at the new
// position. It then pulses `done` for one cycle. Hitting the top or the bottom
// of the screen raises a sticky `collision`, which freezes the physics.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   resetn      in   1  asynchronous active-low reset
//   frame_tick  in   1  one-cycle pulse starting a frame (dropped when busy)
//   flap        in   1  one-cycle flap request (latched until the next UPDATE)
//   restart     in   1  synchronous restart, aborts any frame in progress
//   x           out  8  VGA pixel x        (registered)
//   y           out  7  VGA pixel y        (registered)
//   colour      out  3  VGA pixel colour   (registered)
//   plot        out  1  VGA write enable   (registered)
//   done        out  1  one-cycle end-of-frame pulse (registered)
//   collision   out  1  sticky top/ground hit
//   bird_y      out  7  current top-row y of the sprite
// -----------------------------------------------------------------------------
module bird_datapath #(
    parameter int          BIRD_X      = 40,
    parameter int          BIRD_W      = 4,
    parameter int          BIRD_H      = 4,
    parameter int          Y_START     = 56,
    parameter int          GRAVITY     = 1,
    parameter int          FLAP_V      = 6,
    parameter int          VMAX        = 7,
    parameter int          SCREEN_H    = 120,
    parameter logic [2:0]  BIRD_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       restart,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       collision,
    output logic [6:0] bird_y
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ERASE  = 3'd1,
        S_UPDATE = 3'd2,
        S_DRAW   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Sized views of the parameters used in the datapath arithmetic.
    localparam logic [1:0] COL_LAST = 2'(BIRD_W - 1);
    localparam logic [1:0] ROW_LAST = 2'(BIRD_H - 1);
    localparam logic [7:0] X_BASE   = 8'(BIRD_X);
    localparam logic [6:0] Y_INIT   = 7'(Y_START);
    localparam logic [6:0] GRAV_EXT = 7'(GRAVITY);
    localparam logic [6:0] VMAX_EXT = 7'(VMAX);
    localparam logic [5:0] V_MAX    = 6'(VMAX);
    // Two's-complement upward flap velocity.
    localparam logic [5:0] V_FLAP   = 6'(-FLAP_V);
    // Largest legal top-row y: the sprite must fit above the last row.
    localparam logic [8:0] Y_LIMIT  = 9'(SCREEN_H - BIRD_H);

    // Registered state
    state_t            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [6:0]        bird_y_q, bird_y_d;
    logic signed [5:0] vel_q, vel_d;
    logic              flap_pending_q, flap_pending_d;
    logic              collision_q, collision_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [2:0]        colour_q, colour_d;
    logic              plot_q, plot_d;
    logic              done_q, done_d;

    // Pixel walk helpers
    logic              last_pix_s;
    logic [1:0]        col_nxt_s;
    logic [1:0]        row_nxt_s;

    // Physics helpers
    logic              flap_eff_s;
    logic [6:0]        vel_sum_s;
    logic [5:0]        vel_grav_s;
    logic [5:0]        vel_next_s;
    logic [8:0]        y_sum_s;
    logic [6:0]        y_next_s;
    logic              hit_s;

    // Pixel counter successor: column fastest, wrapping at the sprite width.
    always_comb begin
        last_pix_s = (col_q == COL_LAST) && (row_q == ROW_LAST);
        if (col_q == COL_LAST) begin
            col_nxt_s = 2'd0;
            row_nxt_s = row_q + 2'd1;
        end else begin
            col_nxt_s = col_q + 2'd1;
            row_nxt_s = row_q;
        end
    end

    // Candidate velocity and position for the UPDATE cycle.
    always_comb begin
        // A flap arriving in the UPDATE cycle itself still counts this frame.
        flap_eff_s = flap_pending_q | (flap & ~collision_q);

        // Sign-extended add; vel never exceeds VMAX so 7 bits cannot overflow.
        vel_sum_s = {vel_q[5], vel_q} + GRAV_EXT;
        if ($signed(vel_sum_s) > $signed(VMAX_EXT)) begin
            vel_grav_s = V_MAX;
        end else begin
            vel_grav_s = vel_sum_s[5:0];
        end

        if (flap_eff_s) begin
            vel_next_s = V_FLAP;
        end else begin
            vel_next_s = vel_grav_s;
        end

        // 9-bit two's-complement sum: bit 8 set means the bird went above row 0.
        y_sum_s = {2'b00, bird_y_q} + {{3{vel_next_s[5]}}, vel_next_s};
        if (y_sum_s[8]) begin
            y_next_s = 7'd0;
            hit_s    = 1'b1;
        end else if (y_sum_s > Y_LIMIT) begin
            y_next_s = Y_LIMIT[6:0];
            hit_s    = 1'b1;
        end else begin
            y_next_s = y_sum_s[6:0];
            hit_s    = 1'b0;
        end
    end

    // Next-state, physics commit and registered pixel outputs.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        bird_y_d       = bird_y_q;
        vel_d          = vel_q;
        flap_pending_d = flap_pending_q;
        collision_d    = collision_q;
        x_d            = x_q;
        y_d            = y_q;
        colour_d       = colour_q;
        plot_d         = 1'b0;
        done_d         = 1'b0;

        // Flaps outside UPDATE are latched; repeats within a frame merge.
        if (flap && !collision_q && (state_q != S_UPDATE)) begin
            flap_pending_d = 1'b1;
        end else begin
            flap_pending_d = flap_pending_q;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    // Present erase pixel 0 in the first frame cycle.
                    state_d  = S_ERASE;
                    col_d    = 2'd0;
                    row_d    = 2'd0;
                    plot_d   = 1'b1;
                    x_d      = X_BASE;
                    y_d      = bird_y_q;
                    colour_d = BG_COLOUR;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_ERASE: begin
                if (last_pix_s) begin
                    state_d = S_UPDATE;
                end else begin
                    col_d    = col_nxt_s;
                    row_d    = row_nxt_s;
                    plot_d   = 1'b1;
                    x_d      = X_BASE + {6'd0, col_nxt_s};
                    y_d      = bird_y_q + {5'd0, row_nxt_s};
                    colour_d = BG_COLOUR;
                end
            end

            S_UPDATE: begin
                if (collision_q) begin
                    bird_y_d = bird_y_q;
                    vel_d    = vel_q;
                end else begin
                    bird_y_d    = y_next_s;
                    vel_d       = vel_next_s;
                    collision_d = hit_s;
                end
                flap_pending_d = 1'b0;
                // Draw pixel 0 already uses the freshly computed position.
                state_d  = S_DRAW;
                col_d    = 2'd0;
                row_d    = 2'd0;
                plot_d   = 1'b1;
                x_d      = X_BASE;
                y_d      = bird_y_d;
                colour_d = BIRD_COLOUR;
            end

            S_DRAW: begin
                if (last_pix_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    col_d    = col_nxt_s;
                    row_d    = row_nxt_s;
                    plot_d   = 1'b1;
                    x_d      = X_BASE + {6'd0, col_nxt_s};
                    y_d      = bird_y_q + {5'd0, row_nxt_s};
                    colour_d = BIRD_COLOUR;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart overrides everything, including a same-cycle frame tick.
        if (restart) begin
            state_d        = S_IDLE;
            col_d          = 2'd0;
            row_d          = 2'd0;
            bird_y_d       = Y_INIT;
            vel_d          = 6'sd0;
            flap_pending_d = 1'b0;
            collision_d    = 1'b0;
            x_d            = 8'd0;
            y_d            = 7'd0;
            colour_d       = 3'd0;
            plot_d         = 1'b0;
            done_d         = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            col_q          <= 2'd0;
            row_q          <= 2'd0;
            bird_y_q       <= Y_INIT;
            vel_q          <= 6'sd0;
            flap_pending_q <= 1'b0;
            collision_q    <= 1'b0;
            x_q            <= 8'd0;
            y_q            <= 7'd0;
            colour_q       <= 3'd0;
            plot_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            bird_y_q       <= bird_y_d;
            vel_q          <= vel_d;
            flap_pending_q <= flap_pending_d;
            collision_q    <= collision_d;
            x_q            <= x_d;
            y_q            <= y_d;
            colour_q       <= colour_d;
            plot_q         <= plot_d;
            done_q         <= done_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;
    assign collision = collision_q;
    assign bird_y    = bird_y_q;

endmodule

// File: tb/tb_bird_datapath.sv
// -----------------------------------------------------------------------------
// tb_bird_datapath
//
// Self-checking bench for bird_datapath at default parameters. A frame-level
// reference model (cycle index within the frame, integer physics) predicts
// every cycle's outputs; a compare process checks them on each falling edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bird_datapath;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       flap;
    logic       restart;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;
    logic       collision;
    logic [6:0] bird_y;

    bird_datapath dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .flap       (flap),
        .restart    (restart),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done       (done),
        .collision  (collision),
        .bird_y     (bird_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_phase;   // 0 = idle, else 1-based cycle index within the frame
    int m_y;
    int m_vel;
    bit m_pend;
    bit m_coll;
    bit m_fresh;   // no pixel plotted since reset/restart: x/y/colour still 0
    int e_plot, e_done, e_x, e_y, e_col;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_y = 56; m_vel = 0; m_pend = 1'b0; m_coll = 1'b0;
        m_fresh = 1'b1;
        e_plot = 0; e_done = 0; e_x = 0; e_y = 0; e_col = 0;
    endtask

    task automatic model_step();
        bit fl;
        int v, yn, nc, p;
        if (!resetn || restart) begin
            model_reset();
        end else begin
            fl = flap && !m_coll;
            if (m_phase == NP + 1) begin
                if (!m_coll) begin
                    if (m_pend || fl) v = -6;
                    else v = (m_vel + 1 > 7) ? 7 : m_vel + 1;
                    yn = m_y + v;
                    if (yn < 0) begin m_y = 0; m_coll = 1'b1; end
                    else if (yn > 120 - H) begin m_y = 120 - H; m_coll = 1'b1; end
                    else m_y = yn;
                    m_vel = v;
                end
                m_pend = 1'b0;
            end else if (fl) begin
                m_pend = 1'b1;
            end
            if (m_phase == 0) nc = frame_tick ? 1 : 0;
            else if (m_phase == 2 * NP + 2) nc = 0;
            else nc = m_phase + 1;
            m_phase = nc;
            e_done = (nc == 2 * NP + 2) ? 1 : 0;
            e_plot = ((nc >= 1 && nc <= NP) || (nc >= NP + 2 && nc <= 2 * NP + 1)) ? 1 : 0;
            if (e_plot == 1) begin
                p = (nc <= NP) ? nc - 1 : nc - NP - 2;
                e_x = 40 + p % W;
                e_y = m_y + p / W;
                e_col = (nc <= NP) ? 0 : 6;
                m_fresh = 1'b0;
            end
        end
    endtask

    // Reference model advances on every active edge and on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            model_step();
        end
    end

    // Compare process: outputs are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("plot", plot, e_plot);
                check("done", done, e_done);
                check("bird_y", bird_y, m_y);
                check("collision", collision, m_coll);
                if (e_plot == 1 || m_fresh) begin
                    check("x", x, e_x);
                    check("y", y, e_y);
                    check("colour", colour, e_col);
                end
            end
        end
    end

    // Drive one cycle of inputs at the falling edge.
    task automatic step(input logic t, input logic f, input logic r);
        @(negedge clk);
        frame_tick = t;
        flap       = f;
        restart    = r;
    endtask

    // Tick (optionally with a flap) and wait for done within a bounded window.
    task automatic run_frame(input logic f);
        int cyc;
        cyc = -1;
        step(1'b1, f, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("frame_len", cyc, 2 * NP + 2);
    endtask

    int yexp[3] = '{57, 59, 62};
    int vexp[3] = '{1, 2, 3};
    int ndone;

    initial begin
        frame_tick = 1'b0; flap = 1'b0; restart = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state, hand-computed
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_bird_y", bird_y, 56);
        check("rst_collision", collision, 0);
        check("rst_model_y", m_y, 56);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Pixel stream of the first frame, literal expectations
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 2 * NP + 2; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                check("px1_plot", plot, 1); check("px1_x", x, 40);
                check("px1_y", y, 56); check("px1_col", colour, 0);
            end
            if (i == 16) begin check("px16_x", x, 43); check("px16_y", y, 59); end
            if (i == 17) check("upd_plot", plot, 0);
            if (i == 18) begin
                check("px18_x", x, 40); check("px18_y", y, 57);
                check("px18_col", colour, 6);
            end
            if (i == 33) begin check("px33_x", x, 43); check("px33_y", y, 60); end
            if (i == 34) check("done34", done, 1);
        end
        check("f1_bird_y", bird_y, yexp[0]);
        check("f1_vel", int'(dut.vel_q), vexp[0]);

        // Two more gravity frames
        for (int k = 1; k < 3; k++) begin
            run_frame(1'b0);
            check("grav_bird_y", bird_y, yexp[k]);
            check("grav_vel", int'(dut.vel_q), vexp[k]);
            check("grav_model_y", m_y, yexp[k]);
        end

        // Flap latched in IDLE
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        run_frame(1'b0);
        check("flap_bird_y", bird_y, 50);
        check("flap_vel", int'(dut.vel_q), -6);
        run_frame(1'b0);
        check("flap2_bird_y", bird_y, 45);
        check("flap2_vel", int'(dut.vel_q), -5);
        check("flap2_model_vel", m_vel, -5);

        // Ground hit with no flaps
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (collision === 1'b1) break;
            run_frame(1'b0);
        end
        check("gnd_collision", collision, 1);
        check("gnd_bird_y", bird_y, 116);
        check("gnd_vel", int'(dut.vel_q), 7);
        run_frame(1'b1);
        run_frame(1'b1);
        check("gnd_hold_y", bird_y, 116);

        // Top hit: one gravity frame then flaps down to y=3
        step(1'b0, 1'b0, 1'b1);
        run_frame(1'b0);
        for (int k = 0; k < 9; k++) run_frame(1'b1);
        check("top_pre_y", bird_y, 3);
        run_frame(1'b1);
        check("top_y", bird_y, 0);
        check("top_collision", collision, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("restart_y", bird_y, 56);
        check("restart_collision", collision, 0);

        // Tick during DRAW is dropped
        ndone = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 80; i++) begin
            step((i == 20) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (done === 1'b1) ndone++;
        end
        check("draw_tick_dones", ndone, 1);

        // Restart mid-ERASE
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("abort_plot", plot, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (done === 1'b1) ndone++;
        end
        check("abort_dones", ndone, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, (collision === 1'b1) ? 30 : 400) == 0) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
